// File: rtl/i2c_slave_regs.sv
// i2c_slave_regs: 7-bit I2C target giving a bus master byte access to a register bank
module i2c_slave_regs #(
    parameter logic [6:0] DEV_ADDR = 7'h10,
    parameter int         FILT_LEN = 3
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       i2c_sclk,
    inout  wire        i2c_sdat,
    output logic [7:0] reg_addr,
    output logic       reg_wr_en,
    output logic [7:0] reg_wdata,
    input  logic [7:0] reg_rdata,
    output logic       busy
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RACK
    } state_t;

    localparam int CW = $clog2(FILT_LEN + 1);

    // bit 0 carries SCL, bit 1 carries SDA through the conditioning chain
    logic [1:0]         s1_q, s2_q, f_q, fp_q;
    logic [1:0][CW-1:0] fc_q;
    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [7:0]         sh_q, sh_d, addr_q, addr_d, wdata_q, wdata_d;
    logic               oe_q, oe_d, wr_q, wr_d, busy_q, busy_d, rw_q, rw_d;
    logic               scl_rise, scl_fall, start, stop, hit, load;

    // Synchronize both bus lines, accept a level only after FILT_LEN equal samples, keep last filtered level
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            s1_q <= '1;
            s2_q <= '1;
            f_q  <= '1;
            fp_q <= '1;
            fc_q <= '0;
        end else begin
            s1_q <= {i2c_sdat, i2c_sclk};
            s2_q <= s1_q;
            fp_q <= f_q;
            for (int i = 0; i < 2; i++) begin
                if (s2_q[i] == f_q[i]) fc_q[i] <= '0;
                else if (fc_q[i] == CW'(FILT_LEN - 1)) begin
                    f_q[i]  <= s2_q[i];
                    fc_q[i] <= '0;
                end else fc_q[i] <= fc_q[i] + CW'(1);
            end
        end
    end

    assign scl_rise = f_q[0] & ~fp_q[0];
    assign scl_fall = ~f_q[0] & fp_q[0];
    assign start    = f_q[0] & fp_q[0] & fp_q[1] & ~f_q[1];
    assign stop     = f_q[0] & fp_q[0] & ~fp_q[1] & f_q[1];
    assign hit      = sh_q[6:0] == DEV_ADDR;

    // Protocol state register; reset releases SDA at once
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            oe_q    <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            rw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            oe_q    <= oe_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            rw_q    <= rw_d;
        end
    end

    // Next state: START/STOP override everything, bits move on filtered SCL edges
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        oe_d    = oe_q;
        addr_d  = wr_q ? addr_q + 8'd1 : addr_q;
        wdata_d = wdata_q;
        wr_d    = 1'b0;
        busy_d  = busy_q;
        rw_d    = rw_q;
        load    = 1'b0;
        if (stop) begin
            state_d = IDLE;
            cnt_d   = '0;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else if (start) begin
            state_d = ADDR;
            cnt_d   = '0;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                ADDR, REG, WDATA: if (scl_rise) begin
                    sh_d  = {sh_q[6:0], f_q[1]};
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d   = '0;
                        state_d = state_q == ADDR ? (hit ? ADDR_ACK : IDLE) :
                                  state_q == REG  ? REG_ACK : WDATA_ACK;
                        busy_d  = busy_q | (state_q == ADDR && hit);
                        rw_d    = state_q == ADDR ? f_q[1] : rw_q;
                        addr_d  = state_q == REG ? sh_d : addr_d;
                        wdata_d = state_q == WDATA ? sh_d : wdata_q;
                        wr_d    = state_q == WDATA;
                    end
                end
                ADDR_ACK, REG_ACK, WDATA_ACK: if (scl_fall) begin
                    oe_d = ~oe_q;
                    if (oe_q) begin
                        state_d = state_q == ADDR_ACK ? REG : WDATA;
                        load    = state_q == ADDR_ACK && rw_q;
                    end
                end
                RDATA: if (scl_fall) begin
                    oe_d  = cnt_q != 4'd8 && !sh_q[7];
                    sh_d  = {sh_q[6:0], 1'b0};
                    cnt_d = cnt_q == 4'd8 ? 4'd0 : cnt_q + 4'd1;
                    state_d = cnt_q == 4'd8 ? RACK : RDATA;
                end
                RACK: if (scl_rise) begin
                    cnt_d   = 4'd1;
                    state_d = f_q[1] ? IDLE : RACK;
                    addr_d  = f_q[1] ? addr_q : addr_q + 8'd1;
                end else if (scl_fall && cnt_q == 4'd1) load = 1'b1;
                default: ;
            endcase
            if (load) begin
                state_d = RDATA;
                oe_d    = ~reg_rdata[7];
                sh_d    = {reg_rdata[6:0], 1'b0};
                cnt_d   = 4'd1;
            end
        end
    end

    assign i2c_sdat  = oe_q ? 1'b0 : 1'bz;
    assign reg_addr  = addr_q;
    assign reg_wr_en = wr_q;
    assign reg_wdata = wdata_q;
    assign busy      = busy_q;
endmodule

// File: doc/i2c_slave_regs.md
Name: i2c_slave_regs

Overview:
- I2C target (responder) for 7-bit addressing, the far end of our register-init I2C masters.
- Lets an on-board or external master program a register bank in the FPGA: mode bits, volume and loopback control for the audio path.
- Exposes a simple byte-wide write strobe and read port to the register bank.
- Supports standard/fast mode (SCL <= 400 kHz) with a Clk of 50 MHz.

Parameters:
- DEV_ADDR, 7'h10, 7-bit target address matched after START.
- FILT_LEN, 3, number of consecutive equal samples required to accept an SCL/SDA level change (glitch filter).

Ports:
- Clk  input  1  system clock (50 MHz).
- Rst_n  input  1  asynchronous active-low reset.
- i2c_sclk  input  1  I2C clock from master.
- i2c_sdat  inout  1  I2C data; this block only drives 1'b0 or 1'bz.
- reg_addr  output  8  current register pointer (read/write address).
- reg_wr_en  output  1  one-Clk pulse when a data byte is written.
- reg_wdata  output  8  written data, valid while reg_wr_en is high.
- reg_rdata  input  8  register contents at reg_addr; sampled combinationally by this block.
- busy  output  1  high from an address-matched START until STOP.

Behaviour:
- Reset values:
  - reg_addr = 0, reg_wr_en = 0, reg_wdata = 0, busy = 0.
  - SDA released (z), state = IDLE.
- Input conditioning:
  - 2-FF synchronizer on SCL and SDA.
  - Then a FILT_LEN glitch filter.
  - Edge detect on the filtered signals gives scl_rise / scl_fall.
- START: filtered SDA falls while SCL high.
  - Valid in any state, including repeated START.
  - Go to ADDR; clear bit counter; release SDA.
- STOP: filtered SDA rises while SCL high.
  - Valid in any state; go to IDLE; release SDA; busy = 0.
  - A partial byte is discarded with no reg_wr_en.
- Bit handling:
  - Bits are sampled on scl_rise, MSB first.
  - SDA is changed only on scl_fall.
- States:
  - IDLE: wait for START.
  - ADDR: shift in 8 bits (7 address + R/W).
    - Address mismatch -> IDLE, no ACK driven (NACK).
    - Match -> ADDR_ACK; busy = 1.
  - ADDR_ACK: drive SDA low from the scl_fall after bit 8 until the next scl_fall.
    - R/W = 0 -> REG.
    - R/W = 1 -> load shift register from reg_rdata at that scl_fall -> RDATA.
  - REG: receive 8 bits into reg_addr -> REG_ACK (ACK always).
  - REG_ACK: ACK, then -> WDATA.
  - WDATA: receive 8 bits -> WDATA_ACK.
    - reg_wr_en pulses one Clk after bit-8 scl_rise, with reg_wdata = byte and the current reg_addr.
    - reg_addr increments on the following Clk (8-bit wrap 0xFF -> 0x00).
    - ACK always; then stay in WDATA for further bytes.
  - RDATA: drive bit 7..0 on successive scl_fall (drive low for 0, z for 1) -> RACK.
  - RACK: release SDA; sample the master ACK on scl_rise.
    - ACK (0): reg_addr increments (wrap), reload from reg_rdata at scl_fall, -> RDATA.
    - NACK (1): -> IDLE (wait for STOP/START).
- Repeated START after REG: keeps reg_addr, giving the standard combined write-pointer/read transaction.
- SDA drive latency: <= 2 + FILT_LEN + 2 Clk after the SCL falling edge on the pin.
- Clock stretching is not supported; SCL is never driven.
- Asynchronous reset mid-transaction: immediate release of SDA and all outputs to reset values; the block ignores the bus until the next START.

Test Plan:
- Write, DEV_ADDR=7'h10: START, 0x20, 0x05, 0xA5, STOP.
  - ACK on all three bytes.
  - One reg_wr_en pulse with reg_addr=0x05, reg_wdata=0xA5.
  - reg_addr=0x06 after.
- Address mismatch: START, 0x22 (addr 0x11), 0x05, STOP.
  - SDA never driven low.
  - No reg_wr_en; busy stays 0.
- Combined read: START 0x20, 0x10, repeated START 0x21, master ACK then NACK; reg_rdata model returns addr^0x5A.
  - Bytes read 0x4A then 0x4B.
  - reg_addr ends at 0x11.
- Burst write wrap: pointer 0xFE, data 0x01, 0x02, 0x03.
  - Writes land at 0xFE, 0xFF, 0x00 in order.
  - reg_addr=0x01 after.
- STOP mid-byte: START 0x20, 0x07, 4 data bits, STOP.
  - No reg_wr_en; state IDLE; SDA released.
  - A following full write to pointer 0x07 succeeds.
- Glitch/reset:
  - A 1-Clk SCL glitch during a data bit is ignored (byte still correct).
  - Rst_n low during RDATA releases SDA within the same Clk; busy=0.
